// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: synchronizes arst_n release into dclk, then releases NUM_DOM
// reset domains in ascending order with a programmable gap; supports software re-reset.
module reset_seq_ctrl #(
    parameter int NUM_DOM = 4,
    parameter int CNT_W   = 8
) (
    input  logic               dclk,
    input  logic               arst_n,
    input  logic               scan_mode,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic               sw_rst_req,
    input  logic [NUM_DOM-1:0] sw_rst_mask,
    output logic               sw_rst_ack,
    output logic [NUM_DOM-1:0] rst_n,
    output logic               seq_done,
    output logic               busy
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    typedef enum logic [1:0] {SYNC, HOLD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               sync_s1, sync_s2;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] mask_q, mask_d;
    logic [NUM_DOM-1:0] rst_q, rst_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               sw_seq_q, sw_seq_d;

    logic [CNT_W-1:0]   gap_eff;
    logic               cnt_zero;
    logic               is_last;

    // Lowest set bit of m strictly above position from.
    function automatic logic [IDX_W-1:0] next_above(input logic [NUM_DOM-1:0] m,
                                                    input logic [IDX_W-1:0]   from);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(from))) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic has_above(input logic [NUM_DOM-1:0] m,
                                       input logic [IDX_W-1:0]   from);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (m[i] && (i > int'(from))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_DOM-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign gap_eff  = (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
    assign cnt_zero = (cnt_q == '0);
    assign is_last  = !has_above(mask_q, idx_q);

    // State and datapath registers; every flop, synchronizer included, clears on arst_n.
    // NOTE: sequential state uses non-blocking assignments so all flops update from
    // pre-edge values, independent of statement order.
    always_ff @(posedge dclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= SYNC;
            sync_s1  <= 1'b0;
            sync_s2  <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= CNT_W'(1);
            idx_q    <= '0;
            mask_q   <= '1;
            rst_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            ack_q    <= 1'b0;
            sw_seq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_s1  <= 1'b1;
            sync_s2  <= sync_s1;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            rst_q    <= rst_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            sw_seq_q <= sw_seq_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: if (sync_s2) state_d = RUN;
            HOLD: if (cnt_zero) state_d = RUN;
            RUN:  if (cnt_zero && is_last) state_d = DONE;
            DONE: if (sw_rst_req && (sw_rst_mask != '0)) state_d = HOLD;
            default: state_d = SYNC;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        rst_d    = rst_q;
        done_d   = done_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        sw_seq_d = sw_seq_q;
        case (state_q)
            SYNC: begin
                if (sync_s2) begin
                    gap_d    = gap_eff;
                    cnt_d    = gap_eff - CNT_W'(1);
                    idx_d    = '0;
                    mask_d   = '1;
                    sw_seq_d = 1'b0;
                end
            end
            HOLD: begin
                cnt_d = cnt_zero ? (gap_q - CNT_W'(1)) : (cnt_q - CNT_W'(1));
            end
            RUN: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rst_d[idx_q] = 1'b1;
                    if (is_last) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        ack_d  = sw_seq_q;
                    end else begin
                        // Unmasked domains are jumped over without spending a gap.
                        idx_d = next_above(mask_q, idx_q);
                        cnt_d = gap_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (sw_rst_req) begin
                    if (sw_rst_mask != '0) begin
                        mask_d   = sw_rst_mask;
                        rst_d    = rst_q & ~sw_rst_mask;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        gap_d    = gap_eff;
                        cnt_d    = gap_eff - CNT_W'(1);
                        idx_d    = lowest_set(sw_rst_mask);
                        sw_seq_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Scan mode bypasses the sequencer so test logic sees arst_n directly.
    assign rst_n      = scan_mode ? {NUM_DOM{arst_n}} : rst_q;
    assign seq_done   = done_q;
    assign busy       = busy_q;
    assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed self-checking bench for reset_seq_ctrl: power-on timing, zero gap,
// software re-reset, ignored/empty requests, mid-sequence reset and scan bypass.
module tb_reset_seq_ctrl;

    localparam int NUM_DOM = 4;
    localparam int CNT_W   = 8;

    logic               dclk;
    logic               clk_en;
    logic               arst_n;
    logic               scan_mode;
    logic [CNT_W-1:0]   cfg_gap;
    logic               sw_rst_req;
    logic [NUM_DOM-1:0] sw_rst_mask;
    logic               sw_rst_ack;
    logic [NUM_DOM-1:0] rst_n;
    logic               seq_done;
    logic               busy;

    int checks;
    int errors;

    reset_seq_ctrl #(.NUM_DOM(NUM_DOM), .CNT_W(CNT_W)) dut (
        .dclk        (dclk),
        .arst_n      (arst_n),
        .scan_mode   (scan_mode),
        .cfg_gap     (cfg_gap),
        .sw_rst_req  (sw_rst_req),
        .sw_rst_mask (sw_rst_mask),
        .sw_rst_ack  (sw_rst_ack),
        .rst_n       (rst_n),
        .seq_done    (seq_done),
        .busy        (busy)
    );

    initial dclk = 1'b0;
    always begin
        #5;
        if (clk_en) dclk = ~dclk;
    end

    // Releases arst_n (expected low on entry) and checks every edge E0..last+2
    // against rst_n[k] rising at E2+g*(k+1); optionally pulses sw_rst_req at req_edge.
    task automatic run_power_on(input int gap, input int req_edge, input string tag);
        int g;
        int last;
        logic [NUM_DOM-1:0] exp_rst;
        logic exp_done;
        g    = (gap == 0) ? 1 : gap;
        last = 2 + NUM_DOM * g;
        cfg_gap     = CNT_W'(gap);
        sw_rst_req  = 1'b0;
        sw_rst_mask = '1;
        @(negedge dclk);
        arst_n = 1'b1;
        for (int e = 0; e <= last + 2; e++) begin
            sw_rst_req = (e == req_edge);
            @(posedge dclk);
            #1;
            for (int k = 0; k < NUM_DOM; k++) exp_rst[k] = (e >= 2 + g * (k + 1));
            exp_done = (e >= last);
            checks++;
            if (rst_n !== exp_rst) begin
                errors++;
                $display("FAIL %s_rst E%0d: got %b expected %b", tag, e, rst_n, exp_rst);
            end
            checks++;
            if (seq_done !== exp_done || busy !== !exp_done) begin
                errors++;
                $display("FAIL %s_status E%0d: got done=%b busy=%b expected done=%b busy=%b",
                         tag, e, seq_done, busy, exp_done, !exp_done);
            end
            checks++;
            if (sw_rst_ack !== 1'b0) begin
                errors++;
                $display("FAIL %s_ack E%0d: got %b expected 0", tag, e, sw_rst_ack);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            @(posedge dclk);
            #1;
            checks++;
            if (rst_n !== 4'h0 || seq_done !== 1'b0 || busy !== 1'b1 || sw_rst_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: got rst_n=%b done=%b busy=%b ack=%b expected 0000/0/1/0",
                         rst_n, seq_done, busy, sw_rst_ack);
            end
        end
    endtask

    task automatic test_power_on();
        run_power_on(3, -1, "pon_gap3");
    endtask

    task automatic test_zero_gap();
        arst_n = 1'b0;
        #2;
        run_power_on(0, -1, "pon_gap0");
    endtask

    // Mask 1010, gap 2: bits 1/3 fall at A, rise at A+4/A+6, ack at A+6 only.
    task automatic test_sw_mask();
        logic [NUM_DOM-1:0] exp_rst;
        logic exp_done;
        cfg_gap = 8'd2;
        for (int t = 0; t <= 8; t++) begin
            sw_rst_req  = (t == 0);
            sw_rst_mask = 4'b1010;
            if (t == 1) cfg_gap = 8'd5;
            @(posedge dclk);
            #1;
            exp_rst  = {(t >= 6), 1'b1, (t >= 4), 1'b1};
            exp_done = (t >= 6);
            checks++;
            if (rst_n !== exp_rst) begin
                errors++;
                $display("FAIL sw_mask_rst A+%0d: got %b expected %b", t, rst_n, exp_rst);
            end
            checks++;
            if (seq_done !== exp_done || busy !== !exp_done) begin
                errors++;
                $display("FAIL sw_mask_status A+%0d: got done=%b busy=%b expected done=%b",
                         t, seq_done, busy, exp_done);
            end
            checks++;
            if (sw_rst_ack !== (t == 6)) begin
                errors++;
                $display("FAIL sw_mask_ack A+%0d: got %b expected %b", t, sw_rst_ack, (t == 6));
            end
        end
        sw_rst_req = 1'b0;
        cfg_gap    = 8'd2;
    endtask

    task automatic test_empty_request();
        for (int t = 0; t <= 2; t++) begin
            sw_rst_req  = (t == 0);
            sw_rst_mask = 4'b0000;
            @(posedge dclk);
            #1;
            checks++;
            if (sw_rst_ack !== (t == 0)) begin
                errors++;
                $display("FAIL empty_ack A+%0d: got %b expected %b", t, sw_rst_ack, (t == 0));
            end
            checks++;
            if (rst_n !== 4'hF || seq_done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_state A+%0d: got rst_n=%b done=%b busy=%b expected 1111/1/0",
                         t, rst_n, seq_done, busy);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    // A request during power-on RUN (edge E6) must not disturb timing nor be queued.
    task automatic test_ignored_request();
        arst_n = 1'b0;
        #2;
        run_power_on(3, 6, "ignored");
        for (int t = 0; t < 4; t++) begin
            @(posedge dclk);
            #1;
            checks++;
            if (sw_rst_ack !== 1'b0 || rst_n !== 4'hF) begin
                errors++;
                $display("FAIL ignored_queued +%0d: got ack=%b rst_n=%b expected 0/1111",
                         t, sw_rst_ack, rst_n);
            end
        end
    endtask

    task automatic test_mid_reset();
        arst_n  = 1'b0;
        cfg_gap = 8'd3;
        #2;
        @(negedge dclk);
        arst_n = 1'b1;
        for (int e = 0; e <= 9; e++) @(posedge dclk);
        #1;
        checks++;
        if (rst_n !== 4'b0011) begin
            errors++;
            $display("FAIL mid_pre_rst E9: got %b expected 0011", rst_n);
        end
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (rst_n !== 4'h0 || seq_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: got rst_n=%b done=%b busy=%b expected 0000/0/1",
                     rst_n, seq_done, busy);
        end
        run_power_on(3, -1, "mid_restart");
    endtask

    task automatic test_scan();
        @(negedge dclk);
        #1;
        clk_en    = 1'b0;
        scan_mode = 1'b1;
        #3;
        checks++;
        if (rst_n !== 4'hF) begin
            errors++;
            $display("FAIL scan_high: got %b expected 1111", rst_n);
        end
        arst_n = 1'b0;
        #3;
        checks++;
        if (rst_n !== 4'h0) begin
            errors++;
            $display("FAIL scan_low: got %b expected 0000", rst_n);
        end
        arst_n = 1'b1;
        #3;
        checks++;
        if (rst_n !== 4'hF) begin
            errors++;
            $display("FAIL scan_rehigh: got %b expected 1111", rst_n);
        end
        scan_mode = 1'b0;
        #3;
        checks++;
        if (rst_n !== 4'h0 || busy !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL scan_exit: got rst_n=%b busy=%b done=%b expected 0000/1/0",
                     rst_n, busy, seq_done);
        end
        arst_n = 1'b0;
        clk_en = 1'b1;
        #2;
        run_power_on(1, -1, "post_scan");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        clk_en      = 1'b1;
        arst_n      = 1'b0;
        scan_mode   = 1'b0;
        cfg_gap     = 8'd3;
        sw_rst_req  = 1'b0;
        sw_rst_mask = '0;

        test_reset();
        test_power_on();
        test_zero_gap();
        test_sw_mask();
        test_empty_request();
        test_ignored_request();
        test_mid_reset();
        test_scan();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
